// File: rtl/eth_tx_arbiter_if.sv
// Byte-stream handshake bundle shared by the arbiter's sources and its MAC-side output.
// master drives data/valid/last and samples ready; slave does the reverse.
interface eth_tx_arbiter_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin whole-frame arbiter between two byte sources feeding the Ethernet MAC,
// with inter-frame gap enforcement and abort on source underrun or oversize frames.
module eth_tx_arbiter #(
    parameter int unsigned IFG_CYCLES = 24,
    parameter int unsigned STALL_MAX  = 4,
    parameter int unsigned MAX_BYTES  = 1518
) (
    input  logic             ethTxClk,
    input  logic             rstN,
    eth_tx_arbiter_if.slave  in0,
    eth_tx_arbiter_if.slave  in1,
    eth_tx_arbiter_if.master out,
    output logic             out_abort,
    output logic [1:0]       grant,
    output logic [7:0]       abort_count
);
    localparam int unsigned BW = $clog2(MAX_BYTES + 1);
    localparam int unsigned SW = $clog2(STALL_MAX + 1);
    localparam int unsigned GW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

    state_t        state;
    logic          last_owner;
    logic [BW-1:0] byte_cnt;
    logic [SW-1:0] stall_cnt;
    logic [GW-1:0] gap_cnt;

    logic [7:0] sel_data;
    logic       sel_valid;
    logic       sel_last;
    logic       stall_abort;
    logic       size_abort;
    logic       fwd;
    logic       fire;
    logic       src_ready;
    logic       pick_src1;

    always_comb begin
        sel_data    = grant[1] ? in1.data  : in0.data;
        sel_valid   = grant[1] ? in1.valid : in0.valid;
        sel_last    = grant[1] ? in1.last  : in0.last;
        stall_abort = (state == XFER) && (stall_cnt == SW'(STALL_MAX));
        // A stall abort blocks the handshake so any byte offered that cycle falls into the drain.
        fwd         = (state == XFER) && !stall_abort;
        out.valid   = fwd && sel_valid;
        out.data    = fwd ? sel_data : '0;
        out.last    = fwd && sel_valid && sel_last;
        fire        = fwd && sel_valid && out.ready;
        size_abort  = fire && !sel_last && (byte_cnt == BW'(MAX_BYTES - 1));
        out_abort   = stall_abort || size_abort;
        src_ready   = (fwd && out.ready) || (state == DRAIN);
        in0.ready   = src_ready && grant[0];
        in1.ready   = src_ready && grant[1];
        pick_src1   = last_owner ? !in0.valid : in1.valid;
    end

    always_ff @(posedge ethTxClk) begin
        if (!rstN) begin
            state       <= IDLE;
            grant       <= '0;
            last_owner  <= 1'b1;
            byte_cnt    <= '0;
            stall_cnt   <= '0;
            gap_cnt     <= '0;
            abort_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in0.valid || in1.valid) begin
                        grant     <= pick_src1 ? 2'b10 : 2'b01;
                        byte_cnt  <= '0;
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (out_abort) begin
                        if (abort_count != 8'hFF) begin
                            abort_count <= abort_count + 8'd1;
                        end
                        state <= DRAIN;
                    end else begin
                        if (sel_valid) begin
                            stall_cnt <= '0;
                        end else if (out.ready) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                        if (fire) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                        if (fire && sel_last) begin
                            last_owner <= grant[1];
                            grant      <= '0;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end
                    end
                end
                DRAIN: begin
                    if (sel_valid && sel_last) begin
                        last_owner <= grant[1];
                        grant      <= '0;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(IFG_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: drivers queue expected bytes per source,
// a negedge monitor pops and compares every byte the arbiter hands to the MAC.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
    localparam int unsigned IFG = 24;
    localparam int unsigned MAXB = 1518;

    typedef struct packed {
        logic       abort;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_abort, b_abort;
    logic [1:0] a_grant, b_grant;
    logic [7:0] a_cnt, b_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int aborts_seen = 0;
    exp_t q0[$];
    exp_t q1[$];
    int grant_log[$];
    int gap_log[$];

    eth_tx_arbiter_if a0 ();
    eth_tx_arbiter_if a1 ();
    eth_tx_arbiter_if ao ();
    eth_tx_arbiter_if b0 ();
    eth_tx_arbiter_if b1 ();
    eth_tx_arbiter_if bo ();

    eth_tx_arbiter #(.IFG_CYCLES(IFG), .STALL_MAX(4), .MAX_BYTES(MAXB)) dut_a (
        .ethTxClk(clk), .rstN(rst_n), .in0(a0), .in1(a1), .out(ao),
        .out_abort(a_abort), .grant(a_grant), .abort_count(a_cnt)
    );

    // Small frame limit so the abort counter can be saturated quickly.
    eth_tx_arbiter #(.IFG_CYCLES(2), .STALL_MAX(4), .MAX_BYTES(4)) dut_b (
        .ethTxClk(clk), .rstN(rst_n), .in0(b0), .in1(b1), .out(bo),
        .out_abort(b_abort), .grant(b_grant), .abort_count(b_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_src(input int s, input logic [7:0] d, input logic v, input logic l);
        case (s)
            0: begin a0.data = d; a0.valid = v; a0.last = l; end
            1: begin a1.data = d; a1.valid = v; a1.last = l; end
            default: begin b0.data = d; b0.valid = v; b0.last = l; end
        endcase
    endtask

    function automatic logic src_ready(input int s);
        case (s)
            0: return a0.ready;
            1: return a1.ready;
            default: return b0.ready;
        endcase
    endfunction

    // Call aligned just after a posedge. Bytes below n_exp are expected at the MAC;
    // abort_at marks the byte expected to carry out_abort.
    task automatic drive(input int s, input int n, input int total, input logic [7:0] base,
                         input int n_exp, input int abort_at, input int stall_at, input int stall_len);
        exp_t e;
        logic [7:0] d;
        int t;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                set_src(s, 8'h00, 1'b0, 1'b0);
                repeat (stall_len) @(posedge clk);
                #1;
            end
            d = base + 8'(i);
            set_src(s, d, 1'b1, i == total - 1);
            if (i < n_exp) begin
                e.abort = (i == abort_at);
                e.last  = (i == total - 1);
                e.data  = d;
                if (s == 0) q0.push_back(e);
                else if (s == 1) q1.push_back(e);
            end
            t = 0;
            forever begin
                @(negedge clk);
                if (src_ready(s)) break;
                t++;
                if (t > 4000) begin
                    check($sformatf("ready_timeout_src%0d_byte%0d", s, i), 32'd0, 32'd1);
                    set_src(s, 8'h00, 1'b0, 1'b0);
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        set_src(s, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: byte scoreboard, grant order log and idle-gap measurement.
    initial begin
        exp_t e;
        logic [1:0] prev_grant = 2'b00;
        logic in_frame = 1'b0;
        logic have_end = 1'b0;
        int end_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                have_end = 1'b0;
                prev_grant = 2'b00;
            end else begin
                if (a_grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(int'(a_grant));
                prev_grant = a_grant;
                if (a_abort) begin
                    aborts_seen++;
                    in_frame = 1'b0;
                    have_end = 1'b0;
                end
                if (ao.valid && ao.ready) begin
                    check("grant_onehot", 32'(a_grant == 2'b01 || a_grant == 2'b10), 32'd1);
                    if ((a_grant[1] && q1.size() == 0) || (!a_grant[1] && q0.size() == 0)) begin
                        check("unexpected_byte", {24'd0, ao.data}, 32'hFFFF_FFFF);
                    end else begin
                        e = a_grant[1] ? q1.pop_front() : q0.pop_front();
                        check($sformatf("byte_src%0d", a_grant[1]), 32'({a_abort, ao.last, ao.data}), 32'(e));
                    end
                    if (!in_frame && !a_abort) begin
                        if (have_end) gap_log.push_back(cyc - end_cyc - 1);
                        in_frame = 1'b1;
                    end
                    if (ao.last) begin
                        in_frame = 1'b0;
                        have_end = 1'b1;
                        end_cyc  = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int g0, gp0, ab0;
        int exp_order[6] = '{2, 1, 2, 1, 2, 1};
        set_src(0, 8'h00, 1'b0, 1'b0);
        set_src(1, 8'h00, 1'b0, 1'b0);
        set_src(2, 8'h00, 1'b0, 1'b0);
        b1.data = 8'h00; b1.valid = 1'b0; b1.last = 1'b0;
        ao.ready = 1'b1;
        bo.ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(a_grant), 32'd0);
        check("rst_out_valid", 32'(ao.valid), 32'd0);
        check("rst_abort_count", 32'(a_cnt), 32'd0);
        check("rst_out_abort", 32'(a_abort), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single 64-byte frame from source 0: one-cycle grant latency.
        fork
            drive(0, 64, 64, 8'h00, 64, -1, -1, 0);
            begin
                @(negedge clk);
                check("t1_grant_before", 32'(a_grant), 32'd0);
                @(negedge clk);
                check("t1_grant_latency", 32'(a_grant), 32'd1);
            end
        join
        @(negedge clk);
        check("t1_grant_released", 32'(a_grant), 32'd0);

        // Both sources busy: source 0 owned last, so source 1 goes first, then alternation.
        // Idle samples between frames are the IFG gap plus the IDLE arbitration cycle.
        g0 = grant_log.size();
        gp0 = gap_log.size();
        @(posedge clk);
        #1;
        fork
            begin
                drive(0, 5, 5, 8'h10, 5, -1, -1, 0);
                drive(0, 6, 6, 8'h20, 6, -1, -1, 0);
                drive(0, 7, 7, 8'h30, 7, -1, -1, 0);
            end
            begin
                drive(1, 8, 8, 8'h80, 8, -1, -1, 0);
                drive(1, 9, 9, 8'h90, 9, -1, -1, 0);
                drive(1, 3, 3, 8'hA0, 3, -1, -1, 0);
            end
        join
        check("t2_grant_count", 32'(grant_log.size() - g0), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (grant_log.size() > g0 + k)
                check($sformatf("t2_grant_order_%0d", k), 32'(grant_log[g0 + k]), 32'(exp_order[k]));
        end
        check("t2_gap_count", 32'(gap_log.size() - gp0), 32'd6);
        for (int k = 1; k < 6; k++) begin
            if (gap_log.size() > gp0 + k)
                check($sformatf("t2_ifg_%0d", k), 32'(gap_log[gp0 + k]), 32'(IFG + 1));
        end

        // Source 1 stalls four cycles after byte 10: abort, rest drained silently.
        ab0 = aborts_seen;
        drive(1, 20, 20, 8'h40, 10, -1, 10, 4);
        @(negedge clk);
        check("t3_abort_pulses", 32'(aborts_seen - ab0), 32'd1);
        check("t3_abort_count", 32'(a_cnt), 32'd1);
        check("t3_grant_gap", 32'(a_grant), 32'd0);

        // MAC back-pressure for 20 cycles with valid held: no abort.
        ab0 = aborts_seen;
        @(posedge clk);
        #1;
        fork
            drive(0, 40, 40, 8'h60, 40, -1, -1, 0);
            begin
                for (int t = 0; t < 200 && a_grant == 2'b00; t++) @(negedge clk);
                repeat (10) @(posedge clk);
                #1 ao.ready = 1'b0;
                repeat (20) @(posedge clk);
                #1 ao.ready = 1'b1;
            end
        join
        check("t4_no_abort", 32'(aborts_seen - ab0), 32'd0);
        check("t4_abort_count", 32'(a_cnt), 32'd1);

        // 1600-byte frame: abort rides on byte 1518, the rest is drained.
        ab0 = aborts_seen;
        @(posedge clk);
        #1;
        drive(0, 1600, 1600, 8'h00, MAXB, MAXB - 1, -1, 0);
        @(negedge clk);
        check("t5_abort_pulses", 32'(aborts_seen - ab0), 32'd1);
        check("t5_abort_count", 32'(a_cnt), 32'd2);

        // Reset at byte 30: truncated with no abort, then source 0 wins the tie.
        ab0 = aborts_seen;
        @(posedge clk);
        #1;
        drive(0, 30, 1000, 8'hC0, 30, -1, -1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_grant", 32'(a_grant), 32'd0);
        check("t6_out_valid", 32'(ao.valid), 32'd0);
        check("t6_abort_count", 32'(a_cnt), 32'd0);
        check("t6_out_abort", 32'(a_abort), 32'd0);
        check("t6_no_abort_pulse", 32'(aborts_seen - ab0), 32'd0);
        g0 = grant_log.size();
        @(posedge clk);
        #1;
        fork
            drive(0, 2, 2, 8'hD0, 2, -1, -1, 0);
            drive(1, 2, 2, 8'hE0, 2, -1, -1, 0);
        join
        check("t6_tie_count", 32'(grant_log.size() - g0), 32'd2);
        if (grant_log.size() > g0 + 1) begin
            check("t6_tie_first", 32'(grant_log[g0]), 32'd1);
            check("t6_tie_second", 32'(grant_log[g0 + 1]), 32'd2);
        end

        // Abort counter saturation on the small-frame instance: 5-byte frames, limit 4.
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) drive(2, 5, 5, 8'h00, 0, -1, -1, 0);
        @(negedge clk);
        check("t7_count_3", 32'(b_cnt), 32'd3);
        @(posedge clk);
        #1;
        for (int k = 0; k < 253; k++) drive(2, 5, 5, 8'h00, 0, -1, -1, 0);
        @(negedge clk);
        check("t7_count_256_aborts", 32'(b_cnt), 32'd255);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) drive(2, 5, 5, 8'h00, 0, -1, -1, 0);
        @(negedge clk);
        check("t7_count_saturated", 32'(b_cnt), 32'd255);

        repeat (5) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
